// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: per-channel one-cycle ticks
// and 50 % square waves derived from one system clock.
module tick_generator #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NCH    = 4,
    parameter int CW     = 32,
    parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] busy
);

    localparam logic [CW-1:0] RST_DIV = CW'(CLK_HZ);

    logic [NCH-1:0][CW-1:0] div_q, div_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]         tick_q, tick_d;
    logic [NCH-1:0]         sq_q, sq_d;
    logic [NCH-1:0]         wr_sel;

    // Out-of-range channel indices select nothing.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_sel[k] = cfg_we && (int'(cfg_ch) == k);
        end
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = '0;
        sq_d   = sq_q;
        for (int k = 0; k < NCH; k++) begin
            if (sync || wr_sel[k]) begin
                cnt_d[k] = '0;
                if (wr_sel[k]) begin
                    div_d[k] = cfg_div;
                end
            end else if (div_q[k] == '0) begin
                cnt_d[k] = '0;
            end else if (en) begin
                if (cnt_q[k] == div_q[k] - CW'(1)) begin
                    cnt_d[k]  = '0;
                    tick_d[k] = 1'b1;
                    sq_d[k]   = ~sq_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                div_q[k] <= RST_DIV >> k;
            end
            cnt_q  <= '0;
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < NCH; k++) begin
            busy[k] = |div_q[k];
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule
